// File: rtl/nn_control.sv
// nn_control: training sequencer for the neural-network datapath.
// Walks each epoch through a training phase and a validation phase,
// issuing one-cycle fetch strobes (TR/VL) paced by arch_done, tallies
// validation hits, and strobes SW whenever validation accuracy improves.
module nn_control #(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] TRAIN,
  input  logic [BITS-1:0] VALID,
  input  logic [BITS-1:0] EPOCH,
  input  logic            arch_done,
  input  logic            correct,
  output logic            TR,
  output logic            VL,
  output logic            SW,
  output logic            upd,
  output logic [BITS-1:0] epoch_cnt,
  output logic [BITS-1:0] best_correct,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE, S_TRAIN_ISSUE, S_TRAIN_WAIT, S_VAL_ISSUE,
    S_VAL_WAIT, S_EVAL, S_STORE, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [BITS-1:0] r_train, r_valid, r_epochs;
  logic [BITS-1:0] r_sample_cnt, r_val_correct;
  logic [BITS-1:0] r_epoch_cnt, r_best;
  logic            r_tr, r_vl, r_sw, r_upd, r_done;
  logic            w_train_last, w_val_last, w_store;
  logic [BITS-1:0] w_epoch_inc;

  // First state of an epoch: skip empty phases.
  function automatic state_t phase_entry(input logic [BITS-1:0] tr,
                                         input logic [BITS-1:0] vl);
    if (tr != '0)      return S_TRAIN_ISSUE;
    else if (vl != '0) return S_VAL_ISSUE;
    else               return S_EVAL;
  endfunction

  assign w_train_last = (r_sample_cnt == r_train - BITS'(1));
  assign w_val_last   = (r_sample_cnt == r_valid - BITS'(1));
  assign w_store      = (r_epoch_cnt == '0) || (r_val_correct > r_best);
  assign w_epoch_inc  = r_epoch_cnt + BITS'(1);

  // Next-state selection; outputs are registered from this so they line up with the state.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = (EPOCH == '0) ? S_DONE : phase_entry(TRAIN, VALID);
      end
      S_TRAIN_ISSUE: w_next = S_TRAIN_WAIT;
      S_TRAIN_WAIT: begin
        if (arch_done) begin
          if (w_train_last) w_next = (r_valid != '0) ? S_VAL_ISSUE : S_EVAL;
          else              w_next = S_TRAIN_ISSUE;
        end
      end
      S_VAL_ISSUE: w_next = S_VAL_WAIT;
      S_VAL_WAIT: begin
        if (arch_done) w_next = w_val_last ? S_EVAL : S_VAL_ISSUE;
      end
      S_EVAL: begin
        if (w_store)                    w_next = S_STORE;
        else if (w_epoch_inc == r_epochs) w_next = S_DONE;
        else                            w_next = phase_entry(r_train, r_valid);
      end
      // epoch_cnt was already advanced in EVAL, so compare it directly.
      S_STORE: begin
        if (r_epoch_cnt == r_epochs) w_next = S_DONE;
        else                         w_next = phase_entry(r_train, r_valid);
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, registered strobes and run counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tr          <= 1'b0;
      r_vl          <= 1'b0;
      r_sw          <= 1'b0;
      r_upd         <= 1'b0;
      r_done        <= 1'b0;
      r_train       <= '0;
      r_valid       <= '0;
      r_epochs      <= '0;
      r_sample_cnt  <= '0;
      r_val_correct <= '0;
      r_epoch_cnt   <= '0;
      r_best        <= '0;
    end else begin
      r_state <= w_next;
      r_tr    <= (w_next == S_TRAIN_ISSUE);
      r_vl    <= (w_next == S_VAL_ISSUE);
      r_sw    <= (w_next == S_STORE);
      r_upd   <= (w_next == S_TRAIN_ISSUE) || (w_next == S_TRAIN_WAIT);
      r_done  <= (w_next == S_DONE);
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_train       <= TRAIN;
            r_valid       <= VALID;
            r_epochs      <= EPOCH;
            r_sample_cnt  <= '0;
            r_val_correct <= '0;
            r_epoch_cnt   <= '0;
            r_best        <= '0;
          end
        end
        S_TRAIN_WAIT: begin
          if (arch_done) r_sample_cnt <= w_train_last ? '0 : r_sample_cnt + BITS'(1);
        end
        S_VAL_WAIT: begin
          if (arch_done) begin
            r_val_correct <= r_val_correct + BITS'(correct);
            r_sample_cnt  <= w_val_last ? '0 : r_sample_cnt + BITS'(1);
          end
        end
        // When storing, the hit count is kept one more cycle so STORE can copy it.
        S_EVAL: begin
          r_epoch_cnt <= w_epoch_inc;
          if (!w_store) r_val_correct <= '0;
        end
        S_STORE: begin
          r_best        <= r_val_correct;
          r_val_correct <= '0;
        end
        default: ;
      endcase
    end
  end

  assign TR           = r_tr;
  assign VL           = r_vl;
  assign SW           = r_sw;
  assign upd          = r_upd;
  assign done         = r_done;
  assign epoch_cnt    = r_epoch_cnt;
  assign best_correct = r_best;

endmodule
